uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with a small transmit FIFO, runtime-selectable frame format (parity, stop bits) and configurable data width and oversampling ratio. It is the next generation of the SoC's fixed 8N1 transmitter. It sits between the peripheral bus write path and the TX pin and is driven by the same shared oversampled baud clock as the receiver. Frames are sent back-to-back with no idle gap while the FIFO holds data.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 8, baud-clock ticks per bit; legal range 2..64.
- FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2.
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst_n  in  1  reset; asynchronous assertion, active-low.
- i_baud_clk  in  1  oversampled baud clock (OVERSAMPLE x baud), asynchronous to i_clk.
- i_wr  in  1  write strobe; one FIFO push per cycle high.
- i_data  in  DATA_BITS  write data.
- i_parity  in  2  parity mode: 00 none, 01 odd, 10 even, 11 treated as none.
- i_stop2  in  1  0 = one stop bit, 1 = two stop bits.
- o_tx  out  1  serial output; idle high.
- o_txe  out  1  FIFO not full; a write is accepted when high.
- o_txc  out  1  one-cycle pulse at the end of each frame.
- o_bsy  out  1  high while a frame is on the line.
- o_ovr  out  1  one-cycle pulse when a write is dropped.
- o_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- **Baud tick.** i_baud_clk passes through a 2-flop synchroniser plus one edge register. A one-cycle internal tick fires on each synchronised rising edge.
- **FIFO.** The FIFO is synchronous with binary read and write pointers that wrap modulo FIFO_DEPTH. A separate count register provides full and empty.
  - A push occurs when i_wr=1 and the count is below FIFO_DEPTH.
  - If i_wr=1 while the FIFO is full, the data is dropped and o_ovr pulses the next cycle. This holds even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: when the FIFO is not empty. In that cycle the block pops one word and latches i_parity and i_stop2 into frame registers. Changing the config inputs mid-frame has no effect on the current frame.
  - On entry to START, o_tx goes low and the tick counter clears.
  - Each bit lasts until OVERSAMPLE ticks have occurred since the bit began.
  - START -> DATA.
  - DATA sends DATA_BITS bits, LSB first, from a shift register.
  - DATA -> PARITY if the latched mode is 01 or 10; otherwise DATA -> STOP.
  - Parity bit: even = XOR of the data bits; odd = inverted XOR.
  - STOP: o_tx is high for 1 or 2 bit periods, per the latched i_stop2.
  - STOP end -> START if the FIFO is non-empty (pop in that same cycle, so there is no idle gap); otherwise -> IDLE.
- **Status outputs.** o_txc pulses for one cycle when STOP ends, on every frame. o_bsy is high in every state except IDLE.
- **Registered outputs.** o_tx is registered. o_txe is registered and equals (next count < FIFO_DEPTH).

## Timing
- **Reset values:** o_tx=1, o_txe=1, o_txc=0, o_bsy=0, o_ovr=0, o_level=0; FSM in IDLE; FIFO empty; tick synchroniser cleared. Asserting reset mid-frame forces o_tx high immediately and discards FIFO contents.
- **Write to line, IDLE and empty:**
  - write at cycle N;
  - count/o_level update at N+1;
  - pop and START entry at N+1;
  - o_tx low at N+2.
- **Start bit length.** The first bit is not aligned to the tick grid. It lasts between OVERSAMPLE-1 and OVERSAMPLE tick periods. Every later bit is exactly OVERSAMPLE tick periods.
- **Tick latency.** A tick fires 3 i_clk cycles after an i_baud_clk rising edge; a fixed offset is acceptable. i_baud_clk high and low phases must each last at least 2 i_clk periods.
- **o_txe after a pop from full.** o_txe rises in the cycle after the pop.

## Test plan
- **8N1 frame:** DATA_BITS=8, OVERSAMPLE=8, tick every 4 clk; write 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,1, each bit 32 clk (start 28-32 clk); o_txc pulses once; o_bsy falls with it.
- **7E2 and 7O1:** DATA_BITS=7, i_parity=10, i_stop2=1; write 0x35 -> parity bit 0, two stop bits. Repeat with i_parity=01 -> parity bit 1, one stop bit.
- **Fill and overflow:** FIFO_DEPTH=4; 6 consecutive writes 0x01..0x06 while the line is stalled mid-frame -> 0x01 popped, 0x02..0x05 stored, o_level=4, o_txe=0, o_ovr pulses once for 0x06. Transmitted order is 0x01..0x05 with no idle gap between frames.
- **Config change mid-frame:** switch i_parity 00->10 during the DATA state -> current frame has no parity bit; next frame has an even parity bit.
- **Reset mid-frame:** assert i_rst_n=0 during the DATA state -> o_tx=1 asynchronously; o_level=0, o_bsy=0. After release, a new write transmits correctly.
- **Simultaneous push and pop at full:** write exactly at the STOP->START pop cycle while full -> the write is dropped, o_ovr pulses, o_level=3 next cycle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO.
// Frame format (parity mode, stop bits) is selectable at runtime.
// Data width and oversampling ratio are set by parameters.
// Bit timing comes from a synchronised oversampled baud clock.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_baud_clk,
  input  logic                        i_wr,
  input  logic [DATA_BITS-1:0]        i_data,
  input  logic [1:0]                  i_parity,
  input  logic                        i_stop2,
  output logic                        o_tx,
  output logic                        o_txe,
  output logic                        o_txc,
  output logic                        o_bsy,
  output logic                        o_ovr,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [PW:0]   FULL      = (PW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic                 baud_s1, baud_s2, baud_d, tick;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wptr, rptr;
  logic [PW:0]          count, count_next;
  logic                 push, pop, load;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_next;
  logic [TW-1:0]        tick_cnt, tick_cnt_next;
  logic [3:0]           bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 par_en, par_en_next;
  logic                 par_bit, par_bit_next;
  logic                 stop2, stop2_next;
  logic                 bit_done, tx_next, txc_next;

  // Two-flop synchroniser on the baud clock plus an edge register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      baud_s1 <= 1'b0;
      baud_s2 <= 1'b0;
      baud_d  <= 1'b0;
    end else begin
      baud_s1 <= i_baud_clk;
      baud_s2 <= baud_s1;
      baud_d  <= baud_s2;
    end
  end

  assign tick = baud_s2 & ~baud_d;

  // Writes are accepted only below full.
  // A pop in the same cycle does not make room.
  assign push       = i_wr && (count != FULL);
  assign pop        = load;
  assign head       = mem[rptr];
  assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

  // FIFO data array; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (push) mem[wptr] <= i_data;
  end

  // FIFO pointers, occupancy and write-side status flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      o_txe <= 1'b1;
      o_ovr <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count <= count_next;
      o_txe <= (count_next < FULL);
      o_ovr <= i_wr && (count == FULL);
    end
  end

  assign o_level  = count;
  assign o_bsy    = (state != IDLE);
  assign bit_done = tick && (tick_cnt == TICK_LAST);

  // Next-state, frame datapath and serial output decode
  always_comb begin
    state_next    = state;
    tick_cnt_next = tick ? tick_cnt + TW'(1) : tick_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    par_en_next   = par_en;
    par_bit_next  = par_bit;
    stop2_next    = stop2;
    load          = 1'b0;
    txc_next      = 1'b0;

    case (state)
      IDLE: begin
        if (count != '0) load = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_next    = DATA;
          tick_cnt_next = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          tick_cnt_next = '0;
          shift_next    = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_next = '0;
            state_next   = par_en ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_next    = STOP;
          tick_cnt_next = '0;
        end
      end
      STOP: begin
        if (bit_done) begin
          tick_cnt_next = '0;
          if (stop2 && (bit_cnt == 4'd0)) begin
            bit_cnt_next = 4'd1;
          end else begin
            txc_next = 1'b1;
            if (count != '0) load = 1'b1;
            else             state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Popping a word also latches the frame format,
    // so config changes only affect later frames.
    if (load) begin
      state_next    = START;
      tick_cnt_next = '0;
      bit_cnt_next  = '0;
      shift_next    = head;
      par_en_next   = (i_parity == 2'b01) || (i_parity == 2'b10);
      par_bit_next  = (^head) ^ (i_parity == 2'b01);
      stop2_next    = i_stop2;
    end

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_bit_next;
      default: tx_next = 1'b1;
    endcase
  end

  // State and frame registers; serial output registered from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2    <= 1'b0;
      o_tx     <= 1'b1;
      o_txc    <= 1'b0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_cnt  <= bit_cnt_next;
      shift    <= shift_next;
      par_en   <= par_en_next;
      par_bit  <= par_bit_next;
      stop2    <= stop2_next;
      o_tx     <= tx_next;
      o_txc    <= txc_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo.
// Expected frames are queued at write time.
// A line monitor pops each queued frame at its start bit and checks every bit.
module tb_uart_tx_fifo;
  localparam int unsigned DB = 8;
  localparam int unsigned OS = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned BIT_CLK = OS * 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          baud = 1'b0;
  logic          wr = 1'b0;
  logic [DB-1:0] data = '0;
  logic [1:0]    parity = 2'b00;
  logic          stop2 = 1'b0;
  logic          tx, txe, txc, bsy, ovr;
  logic [$clog2(FD):0] level;

  typedef struct {
    logic [DB-1:0] data;
    logic [1:0]    par;
    logic          stop2;
    bit            b2b;
  } frame_t;

  frame_t      exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned txc_cnt = 0;
  int unsigned ovr_cnt = 0;
  int unsigned bsy_low_cyc = 0;

  uart_tx_fifo #(.DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_DEPTH(FD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_baud_clk(baud), .i_wr(wr), .i_data(data),
    .i_parity(parity), .i_stop2(stop2), .o_tx(tx), .o_txe(txe), .o_txc(txc),
    .o_bsy(bsy), .o_ovr(ovr), .o_level(level)
  );

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #20 baud = ~baud;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (txc === 1'b1) txc_cnt++;
    if (ovr === 1'b1) ovr_cnt++;
    if (bsy !== 1'b1) bsy_low_cyc = cyc;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic wait_n(input int unsigned n, inout bit abort);
    for (int unsigned i = 0; i < n; i++) begin
      if (abort) return;
      @(negedge clk);
      if (!rst_n) abort = 1'b1;
    end
  endtask

  task automatic push_word(input logic [DB-1:0] d, input logic [1:0] p, input logic s, input bit b2b);
    wr = 1'b1;
    data = d;
    exp_q.push_back('{d, p, s, b2b});
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_idle();
    bit tmo = 1'b1;
    for (int unsigned i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bsy === 1'b0) begin
        tmo = 1'b0;
        break;
      end
    end
    check("idle_timeout", 32'(tmo), 0);
    repeat (5) @(negedge clk);
  endtask

  // Line monitor: samples each bit away from its edges.
  // The start bit may be 28..32 clk long, so data samples sit 46+32*j clk after the fall.
  initial begin : monitor
    frame_t      e;
    bit          prev_tx = 1'b1;
    bit          abort;
    bit          prev_exact = 1'b0;
    bit          par_on;
    int unsigned prev_fall = 0;
    int unsigned prev_len = 0;
    int unsigned t;
    forever begin
      @(negedge clk);
      if (rst_n && prev_tx && tx === 1'b0) begin
        t = cyc;
        if (exp_q.size() == 0) begin
          check("frame_queued", 32'(exp_q.size() != 0), 1);
          prev_exact = 1'b0;
        end else begin
          e = exp_q.pop_front();
          if (e.b2b) begin
            check("gap_bsy", 32'(bsy_low_cyc > prev_fall), 0);
            if (prev_exact) check("gap_len", t - prev_fall, prev_len);
          end
          abort = 1'b0;
          par_on = (e.par == 2'b01) || (e.par == 2'b10);
          wait_n(14, abort);
          if (!abort) check("start_bit", 32'(tx), 0);
          wait_n(BIT_CLK, abort);
          for (int unsigned j = 0; j < DB; j++) begin
            if (!abort) check($sformatf("data_bit%0d_%0h", j, e.data), 32'(tx), 32'(e.data[j]));
            wait_n(BIT_CLK, abort);
          end
          if (par_on) begin
            if (!abort) check($sformatf("parity_%0h", e.data), 32'(tx),
                              32'((^e.data) ^ (e.par == 2'b01)));
            wait_n(BIT_CLK, abort);
          end
          if (!abort) check("stop_bit1", 32'(tx), 1);
          if (e.stop2) begin
            wait_n(BIT_CLK, abort);
            if (!abort) check("stop_bit2", 32'(tx), 1);
          end
          prev_fall  = t;
          prev_len   = BIT_CLK * (1 + DB + (par_on ? 1 : 0) + (e.stop2 ? 2 : 1));
          prev_exact = e.b2b && !abort;
        end
      end
      prev_tx = tx;
    end
  end

  initial begin : stim
    bit tmo;
    bit txe_prev;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_txe", 32'(txe), 1);
    check("rst_txc", 32'(txc), 0);
    check("rst_bsy", 32'(bsy), 0);
    check("rst_ovr", 32'(ovr), 0);
    check("rst_level", 32'(level), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 frame: level at N+1, line low at N+2, single txc with bsy falling
    push_word(8'hA5, 2'b00, 1'b0, 1'b0);
    check("n1_level", 32'(level), 1);
    check("n1_tx_high", 32'(tx), 1);
    @(negedge clk);
    check("n2_tx_low", 32'(tx), 0);
    check("n2_bsy", 32'(bsy), 1);
    check("n2_level", 32'(level), 0);
    tmo = 1'b1;
    for (int unsigned i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txc === 1'b1) begin
        tmo = 1'b0;
        break;
      end
    end
    check("txc_timeout", 32'(tmo), 0);
    check("bsy_with_txc", 32'(bsy), 0);
    check("tx_after_frame", 32'(tx), 1);
    @(negedge clk);
    check("txc_one_cycle", 32'(txc), 0);
    wait_idle();

    // Parity and stop-bit formats
    parity = 2'b10; stop2 = 1'b1;
    push_word(8'h35, 2'b10, 1'b1, 1'b0);
    wait_idle();
    parity = 2'b01; stop2 = 1'b0;
    push_word(8'h35, 2'b01, 1'b0, 1'b0);
    wait_idle();
    parity = 2'b11;
    push_word(8'h5A, 2'b11, 1'b0, 1'b0);
    wait_idle();
    parity = 2'b00;

    // Fill and overflow: 0x01 pops at once, 0x02..0x05 fill, 0x06 dropped
    for (int unsigned i = 1; i <= 6; i++) begin
      wr = 1'b1;
      data = DB'(i);
      if (i <= 5) exp_q.push_back('{DB'(i), 2'b00, 1'b0, (i > 1)});
      @(negedge clk);
    end
    wr = 1'b0;
    check("fill_ovr", 32'(ovr), 1);
    check("fill_level", 32'(level), 4);
    check("fill_txe", 32'(txe), 0);
    @(negedge clk);
    check("ovr_one_cycle", 32'(ovr), 0);

    // First pop from full: txe rises together with level dropping to 3
    tmo = 1'b1;
    txe_prev = txe;
    for (int unsigned i = 0; i < 1000; i++) begin
      txe_prev = txe;
      @(negedge clk);
      if (level == 3) begin
        tmo = 1'b0;
        break;
      end
    end
    check("pop_timeout", 32'(tmo), 0);
    check("txe_before_pop", 32'(txe_prev), 0);
    check("txe_after_pop", 32'(txe), 1);
    push_word(8'h07, 2'b00, 1'b0, 1'b1);
    check("refill_level", 32'(level), 4);
    check("refill_txe", 32'(txe), 0);

    // Back-to-back frame lasts exactly 320 clk; write during its final pop cycle
    repeat (318) @(negedge clk);
    wr = 1'b1;
    data = 8'h08;
    @(negedge clk);
    wr = 1'b0;
    check("popfull_ovr", 32'(ovr), 1);
    check("popfull_level", 32'(level), 3);
    check("popfull_txe", 32'(txe), 1);
    wait_idle();

    // Config change mid-frame only affects the following frame
    push_word(8'hC3, 2'b00, 1'b0, 1'b0);
    push_word(8'h81, 2'b10, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    parity = 2'b10;
    wait_idle();
    parity = 2'b00;

    // Reset mid-frame while the line is low in the data bits
    push_word(8'h55, 2'b00, 1'b0, 1'b0);
    push_word(8'h66, 2'b00, 1'b0, 1'b1);
    repeat (60) @(negedge clk);
    tmo = 1'b1;
    for (int unsigned i = 0; i < 100; i++) begin
      if (tx === 1'b0) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("data_low_timeout", 32'(tmo), 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 1);
    check("midrst_level", 32'(level), 0);
    check("midrst_bsy", 32'(bsy), 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    push_word(8'hE7, 2'b00, 1'b0, 1'b0);
    wait_idle();

    check("txc_total", txc_cnt, 13);
    check("ovr_total", ovr_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
